// File: rtl/move_merger.sv
// Purpose : 2048 move engine. Compacts and merges every column of a normalised
//           board toward row 0, walking one cell per clock cycle.
// Latency : fixed 21 cycles from the accepting edge to the return to IDLE.
//           done pulses on the 20th edge after the accept.
// Backpressure: none. start is ignored while a move is in flight. A start held
//           high through the done cycle chains the next move on the exit edge,
//           which gives a 21-cycle period.
// Ports   : clk, rst (async, active-high)
//           start / matrix                   request and normalised board [row][col]
//           busy / done                      move in flight / one-cycle completion pulse
//           merged_matrix, moved, score_add, win   result, held until the next done
module move_merger #(
    parameter int CELL_W  = 12,
    parameter int SCORE_W = 16,
    parameter int WIN_VAL = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [3:0][3:0][CELL_W-1:0]   matrix,
    output logic                          busy,
    output logic                          done,
    output logic [3:0][3:0][CELL_W-1:0]   merged_matrix,
    output logic                          moved,
    output logic [SCORE_W-1:0]            score_add,
    output logic                          win
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CELL_W-1:0] WIN_CELL = CELL_W'(WIN_VAL);
    localparam logic [CELL_W:0]   WIN_DBL  = (CELL_W+1)'(WIN_VAL);

    state_t                        r_state;
    logic [3:0][3:0][CELL_W-1:0]   r_copy;
    logic [3:0][3:0][CELL_W-1:0]   r_buf;
    logic [1:0]                    r_col;
    logic [1:0]                    r_row;
    logic [1:0]                    r_wp;
    logic [CELL_W-1:0]             r_pend;
    logic                          r_pend_vld;
    logic [SCORE_W-1:0]            r_score;
    logic                          r_win;

    logic [CELL_W-1:0]             w_v;
    logic [CELL_W:0]               w_dbl;
    logic                          w_merge;
    logic                          w_accept;
    logic [3:0][3:0][CELL_W-1:0]   w_flush_buf;

    assign w_v     = r_copy[r_row][r_col];
    // Doubling is one bit wider than a cell; values up to 1024 always fit back.
    assign w_dbl   = {w_v, 1'b0};
    // Tiles already at the winning value are terminal and never combine.
    assign w_merge = r_pend_vld && (r_pend == w_v) && (w_v != WIN_CELL);
    // The DONE exit edge behaves as the IDLE entry for start sampling, so a
    // held start chains moves without an extra idle cycle.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Buffer as it stands after the column flush; used both to update r_buf and,
    // on the last column, to publish the result in the same edge.
    always_comb begin
        w_flush_buf = r_buf;
        if (r_pend_vld) begin
            w_flush_buf[r_wp][r_col] = r_pend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_copy        <= '0;
            r_buf         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_wp          <= '0;
            r_pend        <= '0;
            r_pend_vld    <= 1'b0;
            r_score       <= '0;
            r_win         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            merged_matrix <= '0;
            moved         <= 1'b0;
            score_add     <= '0;
            win           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_copy     <= matrix;
                r_buf      <= '0;
                r_col      <= '0;
                r_row      <= '0;
                r_wp       <= '0;
                r_pend_vld <= 1'b0;
                r_score    <= '0;
                r_win      <= 1'b0;
                busy       <= 1'b1;
                r_state    <= S_SCAN;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_SCAN: begin
                        if (w_v != '0) begin
                            if (w_merge) begin
                                r_buf[r_wp][r_col] <= w_dbl[CELL_W-1:0];
                                r_wp               <= r_wp + 2'd1;
                                r_pend_vld         <= 1'b0;
                                r_score            <= r_score + SCORE_W'(w_dbl);
                                if (w_dbl == WIN_DBL) begin
                                    r_win <= 1'b1;
                                end
                            end else if (r_pend_vld) begin
                                r_buf[r_wp][r_col] <= r_pend;
                                r_wp               <= r_wp + 2'd1;
                                r_pend             <= w_v;
                            end else begin
                                r_pend     <= w_v;
                                r_pend_vld <= 1'b1;
                            end
                        end
                        r_row <= r_row + 2'd1;
                        if (r_row == 2'd3) begin
                            r_state <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        r_buf      <= w_flush_buf;
                        r_pend_vld <= 1'b0;
                        r_wp       <= '0;
                        r_row      <= '0;
                        if (r_col != 2'd3) begin
                            r_col   <= r_col + 2'd1;
                            r_state <= S_SCAN;
                        end else begin
                            merged_matrix <= w_flush_buf;
                            moved         <= (w_flush_buf != r_copy);
                            score_add     <= r_score;
                            win           <= r_win;
                            done          <= 1'b1;
                            r_state       <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_merger.sv
module tb_move_merger;

    localparam int CW = 12;
    typedef logic [3:0][3:0][CW-1:0] board_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    board_t       matrix;
    logic         busy;
    logic         done;
    board_t       merged_matrix;
    logic         moved;
    logic [15:0]  score_add;
    logic         win;

    int n_checks = 0;
    int n_fail   = 0;

    move_merger dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .matrix        (matrix),
        .busy          (busy),
        .done          (done),
        .merged_matrix (merged_matrix),
        .moved         (moved),
        .score_add     (score_add),
        .win           (win)
    );

    always #5 clk = ~clk;

    // Reference: per column, drop the empties, then pair equal neighbours
    // front to back; a pair of winning tiles stays apart.
    task automatic model(input board_t b, output board_t r, output int sc,
                         output bit w, output bit mv);
        int vals[$];
        int o;
        int i;
        r  = '0;
        sc = 0;
        w  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vals.delete();
            for (int rr = 0; rr < 4; rr++) begin
                if (b[rr][c] != 0) vals.push_back(int'(b[rr][c]));
            end
            o = 0;
            i = 0;
            while (i < vals.size()) begin
                if (i + 1 < vals.size() && vals[i] == vals[i+1] && vals[i] != 2048) begin
                    r[o][c] = CW'(2 * vals[i]);
                    sc += 2 * vals[i];
                    if (2 * vals[i] == 2048) w = 1'b1;
                    i += 2;
                end else begin
                    r[o][c] = CW'(vals[i]);
                    i += 1;
                end
                o++;
            end
        end
        mv = (r != b);
    endtask

    function automatic board_t rand_board();
        board_t b;
        int     k;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                k = $urandom_range(0, 9);
                if (k < 4)      b[r][c] = '0;
                else if (k < 9) b[r][c] = CW'(1 << $urandom_range(1, 3));
                else            b[r][c] = CW'(1 << $urandom_range(9, 11));
            end
        end
        return b;
    endfunction

    function automatic board_t with_col(input board_t b, input int c,
                                        input int a0, input int a1, input int a2, input int a3);
        board_t t;
        t = b;
        t[0][c] = CW'(a0);
        t[1][c] = CW'(a1);
        t[2][c] = CW'(a2);
        t[3][c] = CW'(a3);
        return t;
    endfunction

    // Drives one move and collects what the DUT reports; callers compare.
    task automatic do_move(input board_t b, output board_t res, output int sc,
                           output bit w, output bit mv, output int lat,
                           output bit busy_e0, output bit busy_after);
        @(negedge clk);
        matrix = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        busy_e0 = busy;
        start   = 1'b0;
        matrix  = rand_board();
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = merged_matrix;
        sc  = int'(score_add);
        w   = win;
        mv  = moved;
        @(posedge clk);
        #1;
        busy_after = busy | done;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        matrix = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (merged_matrix !== '0) begin n_fail++; $display("FAIL reset_matrix: got %h expected 0", merged_matrix); end
        n_checks++; if (moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved: got %b expected 0", moved); end
        n_checks++; if (score_add !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score_add); end
        n_checks++; if (win !== 1'b0) begin n_fail++; $display("FAIL reset_win: got %b expected 0", win); end
    endtask

    task automatic test_directed();
        board_t b, e, res;
        int sc, lat;
        bit w, mv, be0, ba;

        b = with_col('0, 0, 2, 2, 2, 2);
        e = with_col('0, 0, 4, 4, 0, 0);
        do_move(b, res, sc, w, mv, lat, be0, ba);
        n_checks++; if (res !== e) begin n_fail++; $display("FAIL pairs_matrix: got %h expected %h", res, e); end
        n_checks++; if (sc != 8) begin n_fail++; $display("FAIL pairs_score: got %0d expected 8", sc); end
        n_checks++; if (mv !== 1'b1 || w !== 1'b0) begin n_fail++; $display("FAIL pairs_flags: got moved=%b win=%b expected 1 0", mv, w); end
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL pairs_latency: got %0d expected 20", lat); end
        n_checks++; if (be0 !== 1'b1) begin n_fail++; $display("FAIL busy_at_accept: got %b expected 1", be0); end
        n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b expected 0", ba); end

        b = with_col(with_col('0, 1, 0, 2, 0, 2), 2, 2, 2, 4, 0);
        e = with_col(with_col('0, 1, 4, 0, 0, 0), 2, 4, 4, 0, 0);
        do_move(b, res, sc, w, mv, lat, be0, ba);
        n_checks++; if (res !== e) begin n_fail++; $display("FAIL gap_nochain_matrix: got %h expected %h", res, e); end
        n_checks++; if (sc != 8) begin n_fail++; $display("FAIL gap_nochain_score: got %0d expected 8", sc); end

        b = '0;
        for (int c = 0; c < 4; c++) b = with_col(b, c, 2, 4, 8, 16);
        do_move(b, res, sc, w, mv, lat, be0, ba);
        n_checks++; if (res !== b) begin n_fail++; $display("FAIL nomove_matrix: got %h expected %h", res, b); end
        n_checks++; if (mv !== 1'b0 || sc != 0) begin n_fail++; $display("FAIL nomove_flags: got moved=%b score=%0d expected 0 0", mv, sc); end

        b = with_col('0, 3, 1024, 1024, 2048, 2048);
        e = with_col('0, 3, 2048, 2048, 2048, 0);
        do_move(b, res, sc, w, mv, lat, be0, ba);
        n_checks++; if (res !== e) begin n_fail++; $display("FAIL win_matrix: got %h expected %h", res, e); end
        n_checks++; if (w !== 1'b1 || sc != 2048) begin n_fail++; $display("FAIL win_flags: got win=%b score=%0d expected 1 2048", w, sc); end
    endtask

    task automatic test_random();
        board_t b, res, e;
        int sc, esc, lat;
        bit w, ew, mv, emv, be0, ba;
        for (int k = 0; k < 30; k++) begin
            b = rand_board();
            model(b, e, esc, ew, emv);
            do_move(b, res, sc, w, mv, lat, be0, ba);
            n_checks++; if (res !== e) begin n_fail++; $display("FAIL rand%0d_matrix: got %h expected %h", k, res, e); end
            n_checks++; if (sc != esc) begin n_fail++; $display("FAIL rand%0d_score: got %0d expected %0d", k, sc, esc); end
            n_checks++; if (w !== ew || mv !== emv) begin n_fail++; $display("FAIL rand%0d_flags: got win=%b moved=%b expected %b %b", k, w, mv, ew, emv); end
            n_checks++; if (lat != 20) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected 20", k, lat); end
        end
    endtask

    task automatic test_start_ignored_and_reset();
        board_t a, bb, c, e, res;
        int esc, sc, lat;
        bit ew, emv, w, mv, be0, ba, saw;

        a  = with_col(with_col('0, 0, 2, 2, 0, 0), 2, 8, 0, 8, 16);
        bb = '0;
        for (int k = 0; k < 4; k++) bb = with_col(bb, k, 4, 4, 4, 4);
        model(a, e, esc, ew, emv);
        @(negedge clk);
        matrix = a;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) begin start = 1'b1; matrix = bb; end
            if (n == 4) start = 1'b0;
            if (done) begin lat = n; break; end
        end
        n_checks++; if (merged_matrix !== e) begin n_fail++; $display("FAIL ignore_matrix: got %h expected %h", merged_matrix, e); end
        n_checks++; if (lat != 20) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 20", lat); end
        n_checks++; if (int'(score_add) != esc) begin n_fail++; $display("FAIL ignore_score: got %0d expected %0d", score_add, esc); end
        @(posedge clk);

        c = with_col('0, 3, 1024, 1024, 2048, 2048);
        @(negedge clk);
        matrix = c;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        n_checks++; if (merged_matrix !== '0) begin n_fail++; $display("FAIL midreset_matrix: got %h expected 0", merged_matrix); end
        n_checks++; if (moved !== 1'b0 || win !== 1'b0 || score_add !== 16'd0) begin n_fail++; $display("FAIL midreset_results: got moved=%b win=%b score=%0d expected 0 0 0", moved, win, score_add); end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL midreset_nodone: got done pulse expected none"); end

        model(c, e, esc, ew, emv);
        do_move(c, res, sc, w, mv, lat, be0, ba);
        n_checks++; if (res !== e || lat != 20) begin n_fail++; $display("FAIL after_reset_move: got %h lat=%0d expected %h lat=20", res, lat, e); end
        n_checks++; if (w !== ew || sc != esc) begin n_fail++; $display("FAIL after_reset_flags: got win=%b score=%0d expected %b %0d", w, sc, ew, esc); end
    endtask

    task automatic test_back_to_back();
        board_t hist[0:80];
        board_t e;
        int esc;
        bit ew, emv, exp_done;
        @(negedge clk);
        start   = 1'b1;
        matrix  = rand_board();
        hist[0] = matrix;
        for (int c = 0; c < 66; c++) begin
            @(posedge clk);
            #1;
            exp_done = ((c % 21) == 20);
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_done_c%0d: got %b expected %b", c, done, exp_done);
            end
            if (exp_done) begin
                model(hist[c-20], e, esc, ew, emv);
                n_checks++; if (merged_matrix !== e) begin n_fail++; $display("FAIL b2b_matrix_c%0d: got %h expected %h", c, merged_matrix, e); end
                n_checks++; if (int'(score_add) != esc || win !== ew || moved !== emv) begin n_fail++; $display("FAIL b2b_results_c%0d: got score=%0d win=%b moved=%b expected %0d %b %b", c, score_add, win, moved, esc, ew, emv); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_c%0d: got %b expected 1", c, busy); end
            end
            @(negedge clk);
            matrix      = rand_board();
            hist[c + 1] = matrix;
        end
        start = 1'b0;
        repeat (25) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
